// File: rtl/tick_timer_pkg.sv
// Shared mode encoding and width helper for the tick timer bank.
// Mode 11 is reserved and behaves like a periodic pulse.
package tick_timer_pkg;

    typedef enum logic [1:0] {
        MODE_PULSE   = 2'b00,
        MODE_TOGGLE  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_timer_ch.sv
// One programmable tick generator: counts to a terminal value, then pulses
// tick and (in toggle mode) flips sq. One-shot mode runs only while armed.
module tick_timer_ch
    import tick_timer_pkg::*;
#(
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(60000),
    parameter logic [1:0]       DEF_MODE   = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic             en_i,
    input  logic             start_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             busy_o
);

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             busy_q, busy_d;
    logic             active;
    logic             term;

    always_comb begin
        active   = en_i && ((mode_q != MODE_ONESHOT) || busy_q);
        term     = active && (cnt_q == period_q);
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        tick_d   = 1'b0;
        sq_d     = sq_q;
        busy_d   = busy_q;
        // A write or restart on the same edge swallows any terminal event.
        if (we_i) begin
            period_d = cfg_period_i;
            mode_d   = mode_e'(cfg_mode_i);
            cnt_d    = '0;
            busy_d   = 1'b0;
            if (mode_e'(cfg_mode_i) != MODE_TOGGLE) begin
                sq_d = 1'b0;
            end
        end else if (start_i) begin
            cnt_d  = '0;
            busy_d = (mode_q == MODE_ONESHOT);
        end else if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (mode_q == MODE_TOGGLE) begin
                sq_d = ~sq_q;
            end
            if (mode_q == MODE_ONESHOT) begin
                busy_d = 1'b0;
            end
        end else if (active) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= mode_e'(DEF_MODE);
            cnt_q    <= '0;
            period_q <= DEF_PERIOD;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
            busy_q   <= busy_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/tick_timer_bank.sv
// Bank of NUM_CH independent tick generators sharing one config write port.
// Only write decode and port slicing live here.
module tick_timer_bank
    import tick_timer_pkg::*;
#(
    parameter int               NUM_CH     = 4,
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(60000),
    parameter logic [1:0]       DEF_MODE   = 2'b01,
    localparam int              CH_W       = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] start,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [1:0]        cfg_mode,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] busy
);

    // Out-of-range channel numbers match no instance, so such writes are dropped.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic we;
            assign we = cfg_we && (cfg_ch == CH_W'(gi));

            tick_timer_ch #(
                .CNT_W      (CNT_W),
                .DEF_PERIOD (DEF_PERIOD),
                .DEF_MODE   (DEF_MODE)
            ) u_ch (
                .clk          (clk),
                .rst_n        (rst_n),
                .we_i         (we),
                .cfg_period_i (cfg_period),
                .cfg_mode_i   (cfg_mode),
                .en_i         (en[gi]),
                .start_i      (start[gi]),
                .tick_o       (tick[gi]),
                .sq_o         (sq[gi]),
                .busy_o       (busy[gi])
            );
        end
    endgenerate

endmodule
